alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX pipeline stage sitting directly upstream of the 64-bit ALU.
//  Registers decoded operands and control, decodes ALUOp + instruction opcode into the
//  4-bit ALU operation code, and resolves EX/MEM and MEM/WB forwarding into operand A/B.
//  Uses a valid/ready handshake with stall and flush, so the ALU always sees one aligned instruction.
// PARAMETERS
//  DATA_W  64  operand / result width
//  REG_AW  5   register index width (X0..X31; 31 = XZR)
//  OPC_W   11  R-format opcode field width
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous active-low reset
//  in_valid       in   1       decode stage presents an instruction
//  in_ready       out  1       stage can accept this cycle
//  in_rn_data     in   DATA_W  register file read port 1
//  in_rm_data     in   DATA_W  register file read port 2
//  in_imm         in   DATA_W  sign-extended immediate
//  in_rn, in_rm   in   REG_AW  source register indices
//  in_rd          in   REG_AW  destination index (passed through)
//  in_alu_src     in   1       1: operand B = imm, 0: operand B = Rm
//  in_alu_op      in   2       00 ld/st, 01 CBZ, 10 R-type, 11 reserved
//  in_opcode      in   OPC_W   instruction[31:21]
//  flush          in   1       kill held and incoming instruction
//  exm_wr, exm_rd, exm_res  in 1/REG_AW/DATA_W  EX/MEM writeback bypass
//  mwb_wr, mwb_rd, mwb_res  in 1/REG_AW/DATA_W  MEM/WB writeback bypass
//  out_valid      out  1       ALU operands valid
//  out_ready      in   1       downstream consumes this cycle
//  alu_a, alu_b   out  DATA_W  forwarded operands to ALU
//  alu_operation  out  4       ALU operation code
//  store_data     out  DATA_W  forwarded Rm, for STUR
//  out_rd         out  REG_AW  destination index
//  illegal        out  1       undecodable opcode, qualified by out_valid
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, all registered fields=0, alu_operation=4'b0000.
//  Handshake: in_ready = !out_valid | out_ready. Accept on in_valid & in_ready.
//    Latency: exactly 1 cycle from accept to out_valid.
//  Stall: out_valid & !out_ready -> all registered fields hold. Forwarding still re-evaluates every cycle.
//  Flush (priority below reset only): next cycle out_valid=0; a concurrent accept is dropped.
//  Decode (registered at accept): ALUOp 00 -> 0010 ADD; 01 -> 0111 pass B; 10 -> opcode:
//    10001011000 ADD 0010 | 11001011000 SUB 0110 | 10001010000 AND 0000 | 10101010000 ORR 0001.
//    Any other opcode, or ALUOp 11 -> 0010 and illegal=1.
//  Forwarding (combinational on registered rn/rm):
//    src = exm_res if exm_wr & exm_rd==idx & idx!=31;
//    else mwb_res if mwb_wr & mwb_rd==idx & idx!=31;
//    else the registered regfile data. EX/MEM wins when both match.
//  alu_a = fwd(rn). store_data = fwd(rm). alu_b = alu_src ? imm : fwd(rm).
//  Index 31 is never forwarded; the registered data is passed as supplied.
//  All arithmetic is pass-through; the stage does no width change and no sign handling.
// STRUCTURE
//  Shared package alu_pkg: ALU_AND/ORR/ADD/SUB/PASSB/NOR 4-bit localparams,
//    ALUOP_* codes, OPC_ADD/SUB/AND/ORR constants, XZR index.
//  Sub-module alu_control (combinational ALUOp+opcode -> operation, illegal).
//    It is reused by later stages.
//  Forwarding mux is a function instantiated twice; no separate module.
// TESTING
//  1. Reset: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0, alu_operation=0000.
//  2. R-type SUB: opcode 11001011000, rn=5 data 100, rm=6 data 30 ->
//     next cycle alu_operation=0110, alu_a=100, alu_b=30.
//  3. Forward priority: rn=3, exm_wr=1 exm_rd=3 exm_res=7, mwb_wr=1 mwb_rd=3 mwb_res=9 -> alu_a=7;
//     with exm_wr=0 -> alu_a=9; rn=31 with both matching -> alu_a=regfile data.
//  4. Stall: out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs held;
//     out_ready=1 -> next instruction appears on the following cycle.
//  5. Flush during stall with in_valid=1 -> next cycle out_valid=0; dropped instruction never appears.
//  6. ALUOp 10, opcode 11111111111 -> alu_operation=0010, illegal=1;
//     ALUOp 01, alu_src=0 -> 0111 with alu_b=fwd(rm).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: operation codes, ALUOp encodings,
// R-format opcodes and the zero-register index.
package alu_pkg;

    // 4-bit operation codes understood by the ALU
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    // ALUOp field produced by the main decoder
    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-format opcodes, instruction[31:21]
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    // X31 reads as zero register and is never a bypass target
    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps ALUOp plus R-format opcode onto the
// 4-bit ALU operation. Undecodable combinations fall back to ADD and raise
// illegal so later stages can trap without a bogus operation code.
module alu_control
    import alu_pkg::*;
#(
    parameter int OPC_W = 11
) (
    input  logic [1:0]       alu_op,
    input  logic [OPC_W-1:0] opcode,
    output logic [3:0]       operation,
    output logic             illegal
);

    // Decode ALUOp first, then the opcode for R-type instructions
    always_comb begin
        operation = ALU_ADD;
        illegal   = 1'b0;
        unique case (alu_op)
            ALUOP_LDST: operation = ALU_ADD;
            ALUOP_CBZ:  operation = ALU_PASSB;
            ALUOP_RTYPE: begin
                if (opcode == OPC_W'(OPC_ADD)) begin
                    operation = ALU_ADD;
                end else if (opcode == OPC_W'(OPC_SUB)) begin
                    operation = ALU_SUB;
                end else if (opcode == OPC_W'(OPC_AND)) begin
                    operation = ALU_AND;
                end else if (opcode == OPC_W'(OPC_ORR)) begin
                    operation = ALU_ORR;
                end else begin
                    operation = ALU_ADD;
                    illegal   = 1'b1;
                end
            end
            default: begin
                operation = ALU_ADD;
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage in front of the ALU. Captures operands and decoded control on
// accept, holds them while the ALU is stalled, and applies EX/MEM and MEM/WB
// bypassing combinationally so late writebacks are picked up even during a stall.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int OPC_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rn_data,
    input  logic [DATA_W-1:0] in_rm_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_rn,
    input  logic [REG_AW-1:0] in_rm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_alu_src,
    input  logic [1:0]        in_alu_op,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic              flush,
    input  logic              exm_wr,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_res,
    input  logic              mwb_wr,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_operation,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              illegal
);

    localparam logic [REG_AW-1:0] XZR_IDX = REG_AW'(XZR);

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] rn_data_q, rn_data_d;
    logic [DATA_W-1:0] rm_data_q, rm_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [REG_AW-1:0] rn_q,      rn_d;
    logic [REG_AW-1:0] rm_q,      rm_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic              alu_src_q, alu_src_d;
    logic [3:0]        op_q,      op_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_op;
    logic              dec_illegal;
    logic              accept;
    logic [DATA_W-1:0] fwd_rn;
    logic [DATA_W-1:0] fwd_rm;

    // Bypass select: youngest producer (EX/MEM) wins, the zero register never forwards
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] reg_data,
        input logic              e_wr,
        input logic [REG_AW-1:0] e_rd,
        input logic [DATA_W-1:0] e_res,
        input logic              m_wr,
        input logic [REG_AW-1:0] m_rd,
        input logic [DATA_W-1:0] m_res
    );
        logic [DATA_W-1:0] sel;
        sel = reg_data;
        if (idx != XZR_IDX) begin
            if (e_wr && (e_rd == idx)) begin
                sel = e_res;
            end else if (m_wr && (m_rd == idx)) begin
                sel = m_res;
            end
        end
        return sel;
    endfunction

    alu_control #(
        .OPC_W (OPC_W)
    ) u_alu_control (
        .alu_op    (in_alu_op),
        .opcode    (in_opcode),
        .operation (dec_op),
        .illegal   (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next-state: flush kills everything, otherwise load on accept or drain on consume
    always_comb begin
        valid_d   = valid_q;
        rn_data_d = rn_data_q;
        rm_data_d = rm_data_q;
        imm_d     = imm_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        rd_d      = rd_q;
        alu_src_d = alu_src_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            rn_data_d = in_rn_data;
            rm_data_d = in_rm_data;
            imm_d     = in_imm;
            rn_d      = in_rn;
            rm_d      = in_rm;
            rd_d      = in_rd;
            alu_src_d = in_alu_src;
            op_d      = dec_op;
            illegal_d = dec_illegal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rn_data_q <= '0;
            rm_data_q <= '0;
            imm_q     <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            rd_q      <= '0;
            alu_src_q <= 1'b0;
            op_q      <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rn_data_q <= rn_data_d;
            rm_data_q <= rm_data_d;
            imm_q     <= imm_d;
            rn_q      <= rn_d;
            rm_q      <= rm_d;
            rd_q      <= rd_d;
            alu_src_q <= alu_src_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign fwd_rn = fwd_sel(rn_q, rn_data_q, exm_wr, exm_rd, exm_res, mwb_wr, mwb_rd, mwb_res);
    assign fwd_rm = fwd_sel(rm_q, rm_data_q, exm_wr, exm_rd, exm_res, mwb_wr, mwb_rd, mwb_res);

    assign out_valid     = valid_q;
    assign alu_a         = fwd_rn;
    assign store_data    = fwd_rm;
    assign alu_b         = alu_src_q ? imm_q : fwd_rm;
    assign alu_operation = op_q;
    assign out_rd        = rd_q;
    assign illegal       = valid_q && illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: the driver pushes hand-computed expected
// results into a scoreboard queue, a negedge monitor pops and compares on every
// output transfer. Stall and flush behaviour is also checked directly.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_rn_data, in_rm_data, in_imm;
    logic [4:0]  in_rn, in_rm, in_rd;
    logic        in_alu_src;
    logic [1:0]  in_alu_op;
    logic [10:0] in_opcode;
    logic        flush;
    logic        exm_wr, mwb_wr;
    logic [4:0]  exm_rd, mwb_rd;
    logic [63:0] exm_res, mwb_res;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_operation;
    logic [4:0]  out_rd;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rn_data    (in_rn_data),
        .in_rm_data    (in_rm_data),
        .in_imm        (in_imm),
        .in_rn         (in_rn),
        .in_rm         (in_rm),
        .in_rd         (in_rd),
        .in_alu_src    (in_alu_src),
        .in_alu_op     (in_alu_op),
        .in_opcode     (in_opcode),
        .flush         (flush),
        .exm_wr        (exm_wr),
        .exm_rd        (exm_rd),
        .exm_res       (exm_res),
        .mwb_wr        (mwb_wr),
        .mwb_rd        (mwb_rd),
        .mwb_res       (mwb_res),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_operation (alu_operation),
        .store_data    (store_data),
        .out_rd        (out_rd),
        .illegal       (illegal)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output_rd", {59'd0, out_rd}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn rd=%0d op=%b a=%0h b=%0h sd=%0h ill=%0b",
                         out_rd, alu_operation, alu_a, alu_b, store_data, illegal);
                chk("txn_op",  {60'd0, alu_operation}, {60'd0, e.op});
                chk("txn_a",   alu_a,                  e.a);
                chk("txn_b",   alu_b,                  e.b);
                chk("txn_sd",  store_data,             e.sd);
                chk("txn_rd",  {59'd0, out_rd},        {59'd0, e.rd});
                chk("txn_ill", {63'd0, illegal},       {63'd0, e.ill});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] op, input logic [10:0] opc, input logic src,
                         input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic [63:0] rnd, input logic [63:0] rmd, input logic [63:0] imm);
        in_alu_op  = op;
        in_opcode  = opc;
        in_alu_src = src;
        in_rn      = rn;
        in_rm      = rm;
        in_rd      = rd;
        in_rn_data = rnd;
        in_rm_data = rmd;
        in_imm     = imm;
    endtask

    task automatic byp(input logic ew, input logic [4:0] erd, input logic [63:0] eres,
                       input logic mw, input logic [4:0] mrd, input logic [63:0] mres);
        exm_wr  = ew;
        exm_rd  = erd;
        exm_res = eres;
        mwb_wr  = mw;
        mwb_rd  = mrd;
        mwb_res = mres;
    endtask

    // Present the driven instruction until accepted; returns just after the accept edge
    task automatic send(input exp_t e, input bit push, input string tag);
        int n;
        n = 0;
        if (push) sb.push_back(e);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(2'b10, 11'b11001011000, 1'b0, 5'd5, 5'd6, 5'd7, 64'd100, 64'd30, 64'd0);
        byp(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

        // 1. reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
            chk("reset_alu_op",    {60'd0, alu_operation}, 64'd0);
            chk("reset_alu_a",     alu_a, 64'd0);
        end
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

        // 2. R-type SUB
        step();
        drive(2'b10, 11'b11001011000, 1'b0, 5'd5, 5'd6, 5'd7, 64'd100, 64'd30, 64'd0);
        e = '{op: 4'b0110, a: 64'd100, b: 64'd30, sd: 64'd30, rd: 5'd7, ill: 1'b0};
        send(e, 1'b1, "sub");

        // 3. forwarding priority
        step();
        drive(2'b00, 11'd0, 1'b1, 5'd3, 5'd4, 5'd8, 64'd50, 64'd11, 64'd1000);
        byp(1'b1, 5'd3, 64'd7, 1'b1, 5'd3, 64'd9);
        e = '{op: 4'b0010, a: 64'd7, b: 64'd1000, sd: 64'd11, rd: 5'd8, ill: 1'b0};
        send(e, 1'b1, "fwd_exm");

        step();
        byp(1'b0, 5'd3, 64'd7, 1'b1, 5'd3, 64'd9);
        e = '{op: 4'b0010, a: 64'd9, b: 64'd1000, sd: 64'd11, rd: 5'd8, ill: 1'b0};
        send(e, 1'b1, "fwd_mwb");

        step();
        drive(2'b00, 11'd0, 1'b1, 5'd31, 5'd4, 5'd8, 64'd55, 64'd11, 64'd1000);
        byp(1'b1, 5'd31, 64'd7, 1'b1, 5'd31, 64'd9);
        e = '{op: 4'b0010, a: 64'd55, b: 64'd1000, sd: 64'd11, rd: 5'd8, ill: 1'b0};
        send(e, 1'b1, "fwd_xzr");

        step();
        drive(2'b10, 11'b10001011000, 1'b0, 5'd3, 5'd4, 5'd9, 64'd50, 64'd11, 64'd0);
        byp(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 64'd22);
        e = '{op: 4'b0010, a: 64'd50, b: 64'd22, sd: 64'd22, rd: 5'd9, ill: 1'b0};
        send(e, 1'b1, "fwd_rm");

        // 4. stall: held output, next instruction waits, then follows one cycle later
        step();
        byp(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        out_ready = 1'b0;
        drive(2'b10, 11'b10001010000, 1'b0, 5'd1, 5'd2, 5'd10, 64'hF0, 64'h3C, 64'd0);
        e = '{op: 4'b0000, a: 64'hF0, b: 64'h3C, sd: 64'h3C, rd: 5'd10, ill: 1'b0};
        send(e, 1'b1, "stall_a");
        drive(2'b10, 11'b10101010000, 1'b0, 5'd1, 5'd2, 5'd11, 64'h100, 64'h5, 64'd0);
        e = '{op: 4'b0001, a: 64'h100, b: 64'h5, sd: 64'h5, rd: 5'd11, ill: 1'b0};
        sb.push_back(e);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  {63'd0, in_ready},      64'd0);
            chk("stall_out_valid", {63'd0, out_valid},     64'd1);
            chk("stall_op_held",   {60'd0, alu_operation}, 64'd0);
            chk("stall_a_held",    alu_a,                  64'hF0);
            chk("stall_rd_held",   {59'd0, out_rd},        64'd10);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_next_valid", {63'd0, out_valid}, 64'd1);

        // 5. flush during stall kills held and waiting instructions
        step();
        out_ready = 1'b0;
        drive(2'b10, 11'b10001011000, 1'b0, 5'd1, 5'd2, 5'd20, 64'd1, 64'd2, 64'd0);
        send(e, 1'b0, "flush_c");
        drive(2'b10, 11'b11001011000, 1'b0, 5'd1, 5'd2, 5'd21, 64'd3, 64'd4, 64'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_pre_in_ready",  {63'd0, in_ready},  64'd0);
        chk("flush_pre_out_valid", {63'd0, out_valid}, 64'd1);
        step();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_illegal",   {63'd0, illegal},   64'd0);

        // flush concurrent with an accept drops the incoming instruction
        step();
        out_ready = 1'b1;
        drive(2'b10, 11'b10001011000, 1'b0, 5'd1, 5'd2, 5'd22, 64'd5, 64'd6, 64'd0);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_acc_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_acc_out_valid", {63'd0, out_valid}, 64'd0);

        // 6. illegal opcode, CBZ pass-B with forwarded Rm, reserved ALUOp
        step();
        drive(2'b10, 11'b11111111111, 1'b0, 5'd1, 5'd2, 5'd12, 64'd1, 64'd2, 64'd0);
        e = '{op: 4'b0010, a: 64'd1, b: 64'd2, sd: 64'd2, rd: 5'd12, ill: 1'b1};
        send(e, 1'b1, "illegal_opc");

        step();
        drive(2'b01, 11'd0, 1'b0, 5'd0, 5'd9, 5'd13, 64'd5, 64'd77, 64'd999);
        byp(1'b1, 5'd9, 64'd88, 1'b0, 5'd0, 64'd0);
        e = '{op: 4'b0111, a: 64'd5, b: 64'd88, sd: 64'd88, rd: 5'd13, ill: 1'b0};
        send(e, 1'b1, "cbz");

        step();
        byp(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        drive(2'b11, 11'b10001011000, 1'b0, 5'd0, 5'd0, 5'd14, 64'd0, 64'd0, 64'd0);
        e = '{op: 4'b0010, a: 64'd0, b: 64'd0, sd: 64'd0, rd: 5'd14, ill: 1'b1};
        send(e, 1'b1, "aluop_rsvd");

        for (int i = 0; i < 4; i++) step();
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
